int_prio_ctrl: RTL and testbench
================================

# int_prio_ctrl

Six-source priority interrupt controller between the platform interrupt lines and the CPU's `intr`/`int_ack` pins. Latches each request as either edge- or level-triggered and applies per-source enables. Presents one request at a time to the CPU as a one-hot vector, and tracks nested in-service interrupts until the CPU signals end-of-interrupt on `ISR_clr`. Source 0 has the highest priority and source 5 the lowest.

## Interface
- `NUM_SRC`, 6: number of interrupt sources; the RTL supports exactly 6.
- `sys_clk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `irq_in`  in  6  raw device requests, synchronous to `sys_clk`.
- `edge_sel`  in  6  per source: 1 = rising-edge triggered, 0 = level triggered.
- `irq_en`  in  6  per-source enable; 1 = enabled.
- `int_ack`  in  1  CPU acknowledge of the presented request; a 1-cycle pulse.
- `ISR_clr`  in  1  end-of-interrupt from the CPU; a 1-cycle pulse.
- `intr`  out  6  one-hot request to the CPU; registered.
- `isr_num`  out  3  index of the highest-priority in-service source; 3'd7 when none is in service.
- `in_service`  out  6  in-service register.
- `pending`  out  6  pending register, before masking.

## Operation
- Edge-source pending:
  - `irq_d` is `irq_in` delayed by 1 cycle.
  - pend[i] is set when irq_in[i] & ~irq_d[i].
  - pend[i] is cleared when int_ack accepts source i.
  - If set and clear occur in the same cycle, set wins.
- Level-source pending: pend[i] = irq_in[i], re-sampled every cycle; it is never cleared by an ack.
- Candidate = highest-priority bit of pend & irq_en.
- The candidate is eligible when no source is in service, or when its index < isr_num (strictly higher priority). This provides preemptive nesting.
- FSM states:
  - IDLE: intr = 0. If an eligible candidate exists, load intr with its one-hot value and go to ASSERT.
  - ASSERT: intr is frozen. A newly arriving higher-priority source, or masking of the presented source, does not change intr. On int_ack:
    - set in_service[k], where k is the index of intr;
    - clear the edge pending bit k;
    - intr <= 0;
    - go to IDLE.
- ISR_clr, in any state: clear the highest-priority set bit of in_service. If in_service = 0, it is ignored.
- int_ack while in IDLE is ignored.
- int_ack and ISR_clr in the same cycle:
  - The EOI clears the highest-priority in-service bit, computed from the old register value.
  - The ack sets bit k.
  - These are never the same bit, because k < old isr_num.
- A level source that is still high after its EOI is re-presented.
- Reset values: intr = 0, in_service = 0, pending = 0, irq_d = 0, isr_num = 3'd7, state = IDLE.
- Reset mid-handshake abandons the request; an ack arriving after reset is ignored.

## Timing
- irq_in[i] rises, sampled at edge k:
  - edge-type pend[i] = 1 after edge k;
  - intr[i] = 1 after edge k+1.
  - Request latency is 2 cycles.
- Level-type pend[i] follows irq_in with 1-cycle latency.
- int_ack sampled at edge a:
  - intr = 0 after edge a;
  - in_service and isr_num are updated after edge a.
- Minimum re-assertion: the next eligible request appears after edge a+1, giving 1 idle cycle between requests.
- ISR_clr sampled at edge e: in_service and isr_num are updated after edge e. A lower-priority request unblocked by the EOI asserts after edge e+1.
- There is no timeout; ASSERT holds until int_ack.

## Structure
- Shared package `int_pkg` contains:
  - `NUM_SRC` = 6;
  - `NO_ISR` = 3'd7;
  - the state enum IDLE/ASSERT;
  - `onehot6(idx)`, a function returning the one-hot value of an index.
- Sub-module `prio_enc6`:
  - input 6-bit vector; outputs a valid flag and a 3-bit lowest-set index;
  - index = 7 when no bit is set;
  - instantiated twice: once for the candidate, once for isr_num.

## Test plan
- Single edge source: irq_en=6'h3F, edge_sel=6'h3F, pulse irq_in[3] for 1 cycle.
  - intr=6'b001000 two cycles later.
  - int_ack → intr=0, in_service=6'b001000, isr_num=3, pending[3]=0.
  - ISR_clr → isr_num=7.
- Priority: irq_in[4] and irq_in[1] rise in the same cycle → intr=6'b000010 first. After ack, intr stays 0 (4 > 1). After ISR_clr, intr=6'b010000.
- Nesting: while source 2 is in service, raise source 0 → intr=6'b000001.
  - ack → in_service=6'b000101, isr_num=0.
  - ISR_clr → in_service=6'b000100.
  - second ISR_clr → 0.
- Level and mask: edge_sel=0, irq_en[5]=0, hold irq_in[5]=1 → intr stays 0.
  - Set irq_en[5]=1 → intr=6'b100000.
  - ack, then ISR_clr with irq_in still high → re-presented 2 cycles after the EOI.
- Frozen and simultaneous: in ASSERT with source 3 presented, raise source 0 → intr stays 6'b001000 until ack.
  - int_ack and ISR_clr together while in_service=6'b010000 → in_service=6'b001000.
  - New edge on 3 in the ack cycle keeps pending[3]=1.
- Async reset asserted mid-ASSERT → all outputs reset immediately. An int_ack after release leaves in_service=0.

Source files
------------

// File: rtl/int_pkg.sv
// -----------------------------------------------------------------------------
// int_pkg
// Shared definitions for the six-source priority interrupt controller:
// source count, the "nothing in service" index, the handshake FSM state type
// and a helper that turns a source index into its one-hot vector.
// -----------------------------------------------------------------------------
package int_pkg;

   localparam int NUM_SRC = 6;

   // Index value meaning "no source"; larger than any real index, so a
   // plain less-than against it always succeeds.
   localparam logic [2:0] NO_ISR = 3'd7;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ASSERT = 1'b1
   } irq_state_e;

   // One-hot value of a source index; indices 6 and 7 map to all-zero.
   function automatic logic [5:0] onehot6(input logic [2:0] idx);
      logic [5:0] oh;
      case (idx)
         3'd0:    oh = 6'b000001;
         3'd1:    oh = 6'b000010;
         3'd2:    oh = 6'b000100;
         3'd3:    oh = 6'b001000;
         3'd4:    oh = 6'b010000;
         3'd5:    oh = 6'b100000;
         default: oh = 6'b000000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/prio_enc6.sv
// -----------------------------------------------------------------------------
// prio_enc6
// Six-input priority encoder; bit 0 has the highest priority.
// Ports:
//   vec   in  6  request vector
//   valid out 1  at least one bit of vec is set
//   idx   out 3  index of the lowest set bit, NO_ISR (7) when vec is zero
// -----------------------------------------------------------------------------
module prio_enc6
   import int_pkg::*;
(
   input  logic [5:0] vec,
   output logic       valid,
   output logic [2:0] idx
);

   // Scan from the lowest-priority bit down so the last hit is the winner.
   always_comb begin
      idx   = NO_ISR;
      valid = 1'b0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx   = i[2:0];
            valid = 1'b1;
         end else begin
            idx   = idx;
            valid = valid;
         end
      end
   end

endmodule

// File: rtl/int_prio_ctrl.sv
// -----------------------------------------------------------------------------
// int_prio_ctrl
// Six-source priority interrupt controller with edge/level request capture,
// per-source enables, a one-at-a-time request/acknowledge handshake to the
// CPU and preemptive nesting of in-service interrupts.
// Ports:
//   sys_clk    in  1  system clock, rising edge
//   reset      in  1  asynchronous active-low reset
//   irq_in     in  6  raw device requests (synchronous to sys_clk)
//   edge_sel   in  6  1 = rising-edge triggered, 0 = level triggered
//   irq_en     in  6  per-source enable
//   int_ack    in  1  CPU acknowledge of the presented request (pulse)
//   ISR_clr    in  1  end-of-interrupt (pulse)
//   intr       out 6  registered one-hot request to the CPU
//   isr_num    out 3  highest-priority in-service index, 7 when none
//   in_service out 6  in-service register
//   pending    out 6  pending register before masking
// -----------------------------------------------------------------------------
module int_prio_ctrl
   import int_pkg::*;
(
   input  logic       sys_clk,
   input  logic       reset,
   input  logic [5:0] irq_in,
   input  logic [5:0] edge_sel,
   input  logic [5:0] irq_en,
   input  logic       int_ack,
   input  logic       ISR_clr,
   output logic [5:0] intr,
   output logic [2:0] isr_num,
   output logic [5:0] in_service,
   output logic [5:0] pending
);

   irq_state_e state_r;
   irq_state_e state_n_s;
   logic [5:0] irq_d_r;
   logic [5:0] pend_r;
   logic [5:0] pend_n_s;
   logic [5:0] isr_r;
   logic [5:0] isr_n_s;
   logic [2:0] isr_num_r;
   logic [5:0] intr_r;
   logic [5:0] intr_n_s;

   logic [5:0] cand_vec_s;
   logic       cand_valid_s;
   logic [2:0] cand_idx_s;
   logic       cand_elig_s;
   logic [5:0] ack_hit_s;
   logic [5:0] eoi_mask_s;
   logic [5:0] rise_s;
   logic       isr_valid_n_s;
   logic [2:0] isr_idx_n_s;
   logic [2:0] isr_num_n_s;

   assign cand_vec_s = pend_r & irq_en;
   assign rise_s     = irq_in & ~irq_d_r;

   prio_enc6 u_cand_enc (
      .vec   (cand_vec_s),
      .valid (cand_valid_s),
      .idx   (cand_idx_s)
   );

   // isr_num is registered, so the encoder looks at the next in-service value.
   prio_enc6 u_isr_enc (
      .vec   (isr_n_s),
      .valid (isr_valid_n_s),
      .idx   (isr_idx_n_s)
   );

   assign isr_num_n_s = isr_valid_n_s ? isr_idx_n_s : NO_ISR;

   // With nothing in service isr_num_r is 7, so any real candidate qualifies;
   // otherwise only a strictly higher-priority source may nest.
   assign cand_elig_s = cand_valid_s && (cand_idx_s < isr_num_r);

   // Handshake FSM next state and the presented request vector.
   always_comb begin
      state_n_s = state_r;
      intr_n_s  = intr_r;
      ack_hit_s = 6'b000000;
      case (state_r)
         IDLE: begin
            if (cand_elig_s) begin
               intr_n_s  = onehot6(cand_idx_s);
               state_n_s = ASSERT;
            end else begin
               intr_n_s  = 6'b000000;
               state_n_s = IDLE;
            end
         end
         ASSERT: begin
            // intr stays frozen until the CPU acknowledges it.
            if (int_ack) begin
               ack_hit_s = intr_r;
               intr_n_s  = 6'b000000;
               state_n_s = IDLE;
            end else begin
               intr_n_s  = intr_r;
               state_n_s = ASSERT;
            end
         end
         default: begin
            intr_n_s  = 6'b000000;
            state_n_s = IDLE;
         end
      endcase
   end

   // In-service update: EOI removes the old highest-priority bit, the ack adds
   // the presented bit; the two never collide because the ack'd index is
   // strictly above the old isr_num in priority.
   always_comb begin
      eoi_mask_s = 6'b000000;
      if (ISR_clr) begin
         eoi_mask_s = onehot6(isr_num_r);
      end else begin
         eoi_mask_s = 6'b000000;
      end
      isr_n_s = (isr_r | ack_hit_s) & ~eoi_mask_s;
   end

   // Pending capture: edge sources latch a rising edge (which beats a
   // same-cycle ack clear), level sources simply follow irq_in.
   always_comb begin
      pend_n_s = 6'b000000;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (edge_sel[i]) begin
            pend_n_s[i] = rise_s[i] | (pend_r[i] & ~ack_hit_s[i]);
         end else begin
            pend_n_s[i] = irq_in[i];
         end
      end
   end

   // State and output registers.
   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         state_r   <= IDLE;
         irq_d_r   <= 6'b000000;
         pend_r    <= 6'b000000;
         isr_r     <= 6'b000000;
         isr_num_r <= NO_ISR;
         intr_r    <= 6'b000000;
      end else begin
         state_r   <= state_n_s;
         irq_d_r   <= irq_in;
         pend_r    <= pend_n_s;
         isr_r     <= isr_n_s;
         isr_num_r <= isr_num_n_s;
         intr_r    <= intr_n_s;
      end
   end

   assign intr       = intr_r;
   assign isr_num    = isr_num_r;
   assign in_service = isr_r;
   assign pending    = pend_r;

endmodule

// File: tb/tb_int_prio_ctrl.sv
// -----------------------------------------------------------------------------
// tb_int_prio_ctrl
// Self-checking bench: directed scenarios followed by randomized traffic,
// every cycle compared against a behavioural model of the controller.
// -----------------------------------------------------------------------------
module tb_int_prio_ctrl;

   logic       sys_clk = 1'b0;
   logic       reset   = 1'b0;
   logic [5:0] irq_in   = 6'b0;
   logic [5:0] edge_sel = 6'b0;
   logic [5:0] irq_en   = 6'b0;
   logic       int_ack  = 1'b0;
   logic       ISR_clr  = 1'b0;
   logic [5:0] intr;
   logic [2:0] isr_num;
   logic [5:0] in_service;
   logic [5:0] pending;

   int total = 0;
   int bad   = 0;

   // behavioural model state
   logic [5:0] m_pend;
   logic [5:0] m_irqd;
   logic [5:0] m_isr;
   int         m_present;   // presented source index, -1 when nothing presented

   int_prio_ctrl dut (
      .sys_clk    (sys_clk),
      .reset      (reset),
      .irq_in     (irq_in),
      .edge_sel   (edge_sel),
      .irq_en     (irq_en),
      .int_ack    (int_ack),
      .ISR_clr    (ISR_clr),
      .intr       (intr),
      .isr_num    (isr_num),
      .in_service (in_service),
      .pending    (pending)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int lowest(input logic [5:0] v);
      for (int i = 0; i < 6; i++) begin
         if (v[i]) return i;
      end
      return 7;
   endfunction

   task automatic model_reset();
      m_pend    = 6'b0;
      m_irqd    = 6'b0;
      m_isr     = 6'b0;
      m_present = -1;
   endtask

   // Apply the rules for one rising edge using the inputs currently driven.
   task automatic model_edge();
      int top;
      int cand;
      int acked;
      int nxt;
      logic [5:0] rise;
      top   = lowest(m_isr);
      cand  = lowest(m_pend & irq_en);
      acked = -1;
      nxt   = m_present;
      rise  = irq_in & ~m_irqd;
      if (m_present < 0) begin
         if (cand < 6 && cand < top) nxt = cand;
      end else if (int_ack) begin
         acked = m_present;
         nxt   = -1;
      end
      if (acked >= 0) m_isr[acked] = 1'b1;
      if (ISR_clr && top < 6) m_isr[top] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (edge_sel[i]) m_pend[i] = rise[i] | (m_pend[i] & (acked != i));
         else             m_pend[i] = irq_in[i];
      end
      m_irqd    = irq_in;
      m_present = nxt;
   endtask

   task automatic check_all();
      logic [5:0] e_intr;
      e_intr = (m_present >= 0) ? (6'b1 << m_present) : 6'b0;
      check_val("intr",       {2'b0, intr},       {2'b0, e_intr});
      check_val("in_service", {2'b0, in_service}, {2'b0, m_isr});
      check_val("isr_num",    {5'b0, isr_num},    8'(lowest(m_isr)));
      check_val("pending",    {2'b0, pending},    {2'b0, m_pend});
   endtask

   // One clock: model follows the edge, DUT sampled 1 time unit later.
   task automatic step();
      @(posedge sys_clk);
      model_edge();
      #1;
      check_all();
   endtask

   // Asynchronous reset between edges; outputs must clear without a clock.
   task automatic async_reset();
      @(posedge sys_clk);
      model_edge();
      #3;
      reset = 1'b0;
      #1;
      model_reset();
      check_val("rst_intr", {2'b0, intr},       8'h00);
      check_val("rst_isr",  {2'b0, in_service}, 8'h00);
      check_val("rst_num",  {5'b0, isr_num},    8'h07);
      check_val("rst_pend", {2'b0, pending},    8'h00);
      @(negedge sys_clk);
      reset = 1'b1;
   endtask

   initial begin
      model_reset();
      #12;
      check_val("por_intr", {2'b0, intr},    8'h00);
      check_val("por_num",  {5'b0, isr_num}, 8'h07);
      @(negedge sys_clk);
      reset = 1'b1;

      // Single edge source on line 3
      edge_sel = 6'h3F; irq_en = 6'h3F;
      step();
      irq_in = 6'b001000; step();
      check_val("e3_pend", {2'b0, pending}, 8'h08);
      irq_in = 6'b0; step();
      check_val("e3_intr", {2'b0, intr}, 8'h08);
      int_ack = 1'b1; step(); int_ack = 1'b0;
      check_val("e3_ack_isr", {2'b0, in_service}, 8'h08);
      check_val("e3_ack_num", {5'b0, isr_num}, 8'h03);
      ISR_clr = 1'b1; step(); ISR_clr = 1'b0;
      check_val("e3_eoi_num", {5'b0, isr_num}, 8'h07);

      // Priority: 4 and 1 together
      irq_in = 6'b010010; step(); irq_in = 6'b0; step();
      check_val("pr_first", {2'b0, intr}, 8'h02);
      int_ack = 1'b1; step(); int_ack = 1'b0;
      step(); step();
      check_val("pr_blocked", {2'b0, intr}, 8'h00);
      ISR_clr = 1'b1; step(); ISR_clr = 1'b0; step();
      check_val("pr_second", {2'b0, intr}, 8'h10);
      int_ack = 1'b1; step(); int_ack = 1'b0;   // source 4 in service

      // Frozen request and simultaneous ack + EOI
      irq_in = 6'b001000; step(); irq_in = 6'b0; step();
      check_val("fz_pres3", {2'b0, intr}, 8'h08);
      irq_in = 6'b000001; step(); step(); step();
      check_val("fz_frozen", {2'b0, intr}, 8'h08);
      irq_in = 6'b001001; int_ack = 1'b1; ISR_clr = 1'b1; step();
      int_ack = 1'b0; ISR_clr = 1'b0;
      check_val("sim_isr",   {2'b0, in_service}, 8'h08);
      check_val("sim_pend3", {7'b0, pending[3]}, 8'h01);
      step();
      check_val("nest_pres0", {2'b0, intr}, 8'h01);

      // Reset in the middle of a presentation; a later ack is ignored
      async_reset();
      irq_in = 6'b0;
      int_ack = 1'b1; step(); int_ack = 1'b0;
      check_val("post_rst_isr", {2'b0, in_service}, 8'h00);

      // Level source with mask, re-presented after EOI while still high
      edge_sel = 6'h00; irq_en = 6'h1F; irq_in = 6'b100000;
      step(); step(); step();
      check_val("lvl_masked", {2'b0, intr}, 8'h00);
      irq_en = 6'h3F; step(); step();
      check_val("lvl_pres", {2'b0, intr}, 8'h20);
      int_ack = 1'b1; step(); int_ack = 1'b0;
      ISR_clr = 1'b1; step(); ISR_clr = 1'b0;
      step();
      check_val("lvl_repres", {2'b0, intr}, 8'h20);
      int_ack = 1'b1; step(); int_ack = 1'b0;
      ISR_clr = 1'b1; step(); ISR_clr = 1'b0;
      irq_in = 6'b0;

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         if (c % 250 == 0) edge_sel = 6'($urandom);
         if ($urandom_range(0, 15) == 0) irq_en = 6'($urandom);
         for (int b = 0; b < 6; b++) begin
            if ($urandom_range(0, 5) == 0) irq_in[b] = ~irq_in[b];
         end
         if (m_present >= 0) int_ack = ($urandom_range(0, 2) == 0);
         else                int_ack = ($urandom_range(0, 15) == 0);
         ISR_clr = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 599) == 0) async_reset();
         else                             step();
      end
      int_ack = 1'b0; ISR_clr = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
